// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared constants, S-box table and FSM state type for the PRESENT-80 engine
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int RND_W   = 5;

  // Entry n of the 4-bit S-box lives in nibble n (bits 4n+3:4n)
  localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pbox.sv
// rtl/pbox.sv - PRESENT bit permutation, bit i moves to (16*i) mod 63, bit 63 fixed
module pbox
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_d,
  output logic [BLOCK_W-1:0] o_d
);

  for (genvar gi = 0; gi < 63; gi++) begin : g_perm
    assign o_d[(16 * gi) % 63] = i_d[gi];
  end

  assign o_d[63] = i_d[63];

endmodule

// File: rtl/present_sbox.sv
// rtl/present_sbox.sv - single 4-bit PRESENT S-box lookup
module present_sbox
  import present_pkg::*;
(
  input  logic [3:0] i_x,
  output logic [3:0] o_y
);

  assign o_y = SBOX[{i_x, 2'b00} +: 4];

endmodule

// File: rtl/present_ctrl.sv
// rtl/present_ctrl.sv - iterative PRESENT-80 encryptor, one round per clock with valid/ready handshakes
module present_ctrl
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_pt,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_ct,
  output logic               busy
);

  // Only the full 31-round cipher is supported; the last round index is derived from it
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS);

  state_t             r_state;
  logic [BLOCK_W-1:0] r_data;
  logic [KEY_W-1:0]   r_key;
  logic [RND_W-1:0]   r_rnd;
  logic [BLOCK_W-1:0] r_out_ct;
  logic               r_out_valid;

  logic [BLOCK_W-1:0] w_add;
  logic [BLOCK_W-1:0] w_sub;
  logic [BLOCK_W-1:0] w_perm;
  logic [KEY_W-1:0]   w_key_rot;
  logic [3:0]         w_key_sb;
  logic [KEY_W-1:0]   w_key_next;

  // Round datapath: add round key, substitute every nibble, permute
  assign w_add = r_data ^ r_key[79:16];

  for (genvar gn = 0; gn < 16; gn++) begin : g_sbox
    present_sbox u_sbox (
      .i_x (w_add[4*gn +: 4]),
      .o_y (w_sub[4*gn +: 4])
    );
  end

  pbox u_pbox (
    .i_d (w_sub),
    .o_d (w_perm)
  );

  // Key schedule: rotate left by 61, substitute top nibble, mix in round counter.
  // On the last round this same result supplies the final whitening key.
  assign w_key_rot = {r_key[18:0], r_key[79:19]};

  present_sbox u_key_sbox (
    .i_x (w_key_rot[79:76]),
    .o_y (w_key_sb)
  );

  assign w_key_next = {w_key_sb, w_key_rot[75:20], w_key_rot[19:15] ^ r_rnd, w_key_rot[14:0]};

  // Control FSM with the cipher state, key, round counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_key       <= '0;
      r_rnd       <= '0;
      r_out_ct    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data  <= in_pt;
            r_key   <= in_key;
            r_rnd   <= RND_W'(1);
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_data <= w_perm;
          r_key  <= w_key_next;
          r_rnd  <= r_rnd + RND_W'(1);
          if (r_rnd == LAST_RND) begin
            r_out_ct    <= w_perm ^ w_key_next[79:16];
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign out_valid = r_out_valid;
  assign out_ct    = r_out_ct;

endmodule

// File: tb/tb_present_ctrl.sv
// tb/tb_present_ctrl.sv - scoreboard bench for present_ctrl using known PRESENT-80 vectors
module tb_present_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pt;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_ct;
  logic        busy;

  localparam logic [63:0] PT_F  = {64{1'b1}};
  localparam logic [79:0] KEY_F = {80{1'b1}};

  typedef struct {
    logic [63:0] ct;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycle    = 0;
  int   acc_cnt  = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  present_ctrl #(.ROUNDS(31)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [63:0] ref_ct(input logic [63:0] pt, input logic [79:0] key);
    logic [143:0] k;
    k = {pt, key};
    case (k)
      {64'h0, 80'h0}: return 64'h5579C1387B228445;
      {64'h0, KEY_F}: return 64'hE72C46C0F5945049;
      {PT_F,  80'h0}: return 64'hA112FFC72F68417B;
      {PT_F,  KEY_F}: return 64'h3333DCD3213210D2;
      default:        return 64'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] pt, input logic [79:0] key);
    int n;
    n = 0;
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("issue_timeout", 80'(n), 80'(0));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("drain_timeout", 80'(exp_q.size()), 80'(0));
  endtask

  // Acceptance logger: records the expected result for every accepted request
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && in_valid && in_ready) begin
        e.ct  = ref_ct(in_pt, in_key);
        e.acc = cycle + 1;
        exp_q.push_back(e);
        prev_acc = last_acc;
        last_acc = cycle + 1;
        acc_cnt++;
      end
    end
  end

  // Output monitor: compares each new result against the scoreboard head
  initial begin
    logic prev_v;
    exp_t m;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_ct);
        end else begin
          m = exp_q.pop_front();
          chk("ciphertext", 80'(out_ct), 80'(m.ct));
          chk("latency", 80'(cycle - m.acc), 80'(31));
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    int a0;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    out_ready = 1'b1;
    tick();
    chk("rst_in_ready", 80'(in_ready), 80'(1));
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_out_ct", 80'(out_ct), 80'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer vectors
    issue(64'h0, 80'h0);
    chk("busy_in_run", 80'(busy), 80'(1));
    drain();
    issue(64'h0, KEY_F);
    drain();
    issue(PT_F, 80'h0);
    drain();

    // Backpressure, with inputs changed and in_valid held during RUN/DONE
    out_ready = 1'b0;
    issue(PT_F, KEY_F);
    in_pt    = 64'h0123456789ABCDEF;
    in_key   = 80'h13579BDF02468ACE1357;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("done_timeout", 80'(n), 80'(0));
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 80'(out_valid), 80'(1));
      chk("bp_out_ct", 80'(out_ct), 80'(64'h3333DCD3213210D2));
      chk("bp_in_ready", 80'(in_ready), 80'(0));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid", 80'(out_valid), 80'(0));
    chk("hs_in_ready", 80'(in_ready), 80'(1));
    chk("hs_busy", 80'(busy), 80'(0));
    chk("idle_keeps_ct", 80'(out_ct), 80'(64'h3333DCD3213210D2));

    // Back-to-back: in_valid held high, plaintext flips every cycle
    a0       = acc_cnt;
    in_key   = 80'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 67; i++) begin
      in_pt = (i % 2 == 1) ? PT_F : 64'h0;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 80'(acc_cnt - a0), 80'(3));
    chk("b2b_interval", 80'(last_acc - prev_acc), 80'(33));
    drain();

    // Reset in the middle of a run
    issue(64'h0, 80'h0);
    repeat (14) tick();
    chk("pre_rst_busy", 80'(busy), 80'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 80'(in_ready), 80'(1));
    chk("mid_rst_busy", 80'(busy), 80'(0));
    chk("mid_rst_out_valid", 80'(out_valid), 80'(0));
    chk("mid_rst_out_ct", 80'(out_ct), 80'(0));
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    issue(64'h0, 80'h0);
    drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
